// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone B3 burst slave.
package wb_burst_pkg;

   localparam logic [2:0] CLASSIC = 3'b000;
   localparam logic [2:0] CONST   = 3'b001;
   localparam logic [2:0] INCR    = 3'b010;
   localparam logic [2:0] EOB     = 3'b111;

   typedef enum logic [1:0] {LINEAR, WRAP4, WRAP8, WRAP16} bte_e;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_BURST} state_e;

   // Reserved cycle types fall back to classic behaviour.
   function automatic logic cti_is_burst(input logic [2:0] cti);
      return (cti == CONST) || (cti == INCR);
   endfunction

endpackage

// File: rtl/wb_burst_slave_if.sv
// Wishbone B3 bus bundle between a master and the burst slave.
interface wb_burst_slave_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] wb_adr_i;
   logic [DW-1:0] wb_dat_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic [2:0]    wb_cti_i;
   logic [1:0]    wb_bte_i;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic          wb_rty_o;
   logic          adr_mismatch_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, adr_mismatch_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, adr_mismatch_o
   );

endinterface

// File: rtl/wb_burst_addr_gen.sv
// Next burst word offset: the low bits selected by bte increment, upper bits hold.
module wb_burst_addr_gen
   import wb_burst_pkg::*;
#(
   parameter int OW        = 30,
   parameter int MEM_WORDS = 1024
) (
   input  logic [OW-1:0] cur,
   input  bte_e          bte,
   output logic [OW-1:0] nxt
);
   localparam int IW = $clog2(MEM_WORDS);

   logic [OW-1:0] mask;
   logic [OW-1:0] inc;

   always_comb begin
      case (bte)
         WRAP4:   mask = OW'(3);
         WRAP8:   mask = OW'(7);
         WRAP16:  mask = OW'(15);
         default: mask = OW'(MEM_WORDS - 1);
      endcase
      inc = cur + OW'(1);
      nxt = (cur & ~mask) | (inc & mask);
   end

endmodule

// File: rtl/wb_burst_slave.sv
// Wishbone B3 slave with word memory: classic cycles, registered-feedback bursts,
// optional wait states before the first beat and error response outside the window.
module wb_burst_slave
   import wb_burst_pkg::*;
#(
   parameter int          AW          = 32,
   parameter int          DW          = 32,
   parameter int          MEM_WORDS   = 1024,
   parameter logic [AW-1:0] BASE_ADDR = '0,
   parameter int          WAIT_STATES = 0
) (
   input logic             wb_clk_i,
   input logic             wb_rst_ni,
   wb_burst_slave_if.slave wb
);
   localparam int         IW      = $clog2(MEM_WORDS);
   localparam int         OW      = AW - 2;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_e        state, state_nxt;
   logic [3:0]    wait_cnt;
   logic [OW-1:0] beat_off, off_in, off_nxt, issue_off;
   logic [DW-1:0] mem [MEM_WORDS];
   logic          req, beat_out, beat_done, burst_end;
   logic          issue, issue_ok, commit_wr, mismatch;

   assign off_in    = OW'((wb.wb_adr_i - BASE_ADDR) >> 2);
   assign req       = wb.wb_cyc_i & wb.wb_stb_i;
   assign beat_out  = wb.wb_ack_o | wb.wb_err_o;
   // A beat completes on the edge where the master still strobes while ack/err is out.
   assign beat_done = beat_out & req;
   assign burst_end = beat_done & ~cti_is_burst(wb.wb_cti_i);
   assign issue_ok  = (issue_off >> IW) == '0;
   assign commit_wr = wb_rst_ni & beat_done & wb.wb_ack_o & wb.wb_we_i;
   assign wb.wb_rty_o = 1'b0;

   wb_burst_addr_gen #(.OW(OW), .MEM_WORDS(MEM_WORDS)) u_addr_gen (
      .cur (beat_off),
      .bte (bte_e'(wb.wb_bte_i)),
      .nxt (off_nxt)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         // Ignore the strobe still held over the completing classic beat.
         ST_IDLE:  if (req && !beat_out) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (!wb.wb_cyc_i) state_nxt = ST_IDLE;
                   else if (wait_cnt == 4'd0) state_nxt = ST_RESP;
         ST_RESP:  if (!wb.wb_cyc_i) state_nxt = ST_IDLE;
                   else if (wb.wb_stb_i) state_nxt = cti_is_burst(wb.wb_cti_i) ? ST_BURST : ST_IDLE;
         ST_BURST: if (!wb.wb_cyc_i || burst_end) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      issue     = 1'b0;
      issue_off = beat_off;
      mismatch  = 1'b0;
      case (state)
         ST_RESP: begin
            issue     = req;
            issue_off = off_in;
         end
         ST_BURST: begin
            issue     = req & ~burst_end;
            issue_off = beat_done ? off_nxt : beat_off;
            mismatch  = beat_done & (off_in != beat_off);
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wait_cnt          <= 4'd0;
         beat_off          <= '0;
         wb.wb_ack_o       <= 1'b0;
         wb.wb_err_o       <= 1'b0;
         wb.wb_dat_o       <= '0;
         wb.adr_mismatch_o <= 1'b0;
      end else begin
         wb.wb_ack_o       <= issue & issue_ok;
         wb.wb_err_o       <= issue & ~issue_ok;
         wb.adr_mismatch_o <= mismatch;
         if (state == ST_IDLE && state_nxt == ST_WAIT) wait_cnt <= WS_LOAD;
         else if (state == ST_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
         if (issue) begin
            beat_off <= issue_off;
            if (!issue_ok)          wb.wb_dat_o <= '0;
            else if (!wb.wb_we_i)   wb.wb_dat_o <= mem[issue_off[IW-1:0]];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (commit_wr)
         for (int b = 0; b < 4; b++)
            if (wb.wb_sel_i[b]) mem[beat_off[IW-1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
   end

endmodule

// File: tb/tb_wb_burst_slave.sv
// Randomized bench for wb_burst_slave: two instances (0 and 3 wait states) checked
// against a word-array memory model and the bus timing rules.
module tb_wb_burst_slave;
   import wb_burst_pkg::*;

   localparam int MW = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] adr = '0, dat = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic [2:0]  cti = CLASSIC;
   logic [1:0]  bte = 2'd0;
   int          dsel = 0;

   logic        ack, err, rty, mism;
   logic [31:0] rdat;

   logic [31:0] mdl [2][MW];
   logic [31:0] last_rd;
   logic [31:0] brd [16];
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   wb_burst_slave_if #(.AW(32), .DW(32)) bus0 ();
   wb_burst_slave_if #(.AW(32), .DW(32)) bus3 ();

   assign bus0.wb_adr_i = adr;  assign bus3.wb_adr_i = adr;
   assign bus0.wb_dat_i = dat;  assign bus3.wb_dat_i = dat;
   assign bus0.wb_sel_i = sel;  assign bus3.wb_sel_i = sel;
   assign bus0.wb_we_i  = we;   assign bus3.wb_we_i  = we;
   assign bus0.wb_cti_i = cti;  assign bus3.wb_cti_i = cti;
   assign bus0.wb_bte_i = bte;  assign bus3.wb_bte_i = bte;
   assign bus0.wb_cyc_i = cyc & (dsel == 0);
   assign bus0.wb_stb_i = stb & (dsel == 0);
   assign bus3.wb_cyc_i = cyc & (dsel == 1);
   assign bus3.wb_stb_i = stb & (dsel == 1);

   assign ack  = (dsel == 1) ? bus3.wb_ack_o       : bus0.wb_ack_o;
   assign err  = (dsel == 1) ? bus3.wb_err_o       : bus0.wb_err_o;
   assign rty  = (dsel == 1) ? bus3.wb_rty_o       : bus0.wb_rty_o;
   assign mism = (dsel == 1) ? bus3.adr_mismatch_o : bus0.adr_mismatch_o;
   assign rdat = (dsel == 1) ? bus3.wb_dat_o       : bus0.wb_dat_o;

   wb_burst_slave #(.AW(32), .DW(32), .MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
      .wb_clk_i (clk), .wb_rst_ni (rst_n), .wb (bus0));
   wb_burst_slave #(.AW(32), .DW(32), .MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
      .wb_clk_i (clk), .wb_rst_ni (rst_n), .wb (bus3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
      return o;
   endfunction

   function automatic int nxt_w(input int w, input logic [1:0] bt);
      int n;
      if (bt == 2'd0) return (w + 1) % MW;
      n = 2 << bt;
      return (w / n) * n + (w + 1) % n;
   endfunction

   task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int   n = 0;
      int   wi;
      logic ok;
      ok = a < 32'(4 * MW);
      wi = int'(a >> 2);
      adr = a; dat = d; sel = s; we = w; cti = CLASSIC; bte = 2'd0; cyc = 1'b1; stb = 1'b1;
      do begin tick(); n++; end while (!(ack || err) && n < 40);
      chk("classic_latency", 32'(n), 32'(2 + 3 * dsel));
      chk("classic_resp", 32'({err, ack}), ok ? 32'd1 : 32'd2);
      if (!w) begin
         last_rd = rdat;
         chk("classic_rdata", rdat, ok ? mdl[dsel][wi] : 32'h0);
      end
      tick();
      chk("classic_no_back2back", 32'(ack | err), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      if (w && ok) mdl[dsel][wi] = bmerge(mdl[dsel][wi], d, s);
   endtask

   task automatic burst(input logic w, input logic [31:0] a0, input logic [1:0] bt, input int nb,
                        input int bad, input logic abort);
      int          wi [16];
      logic [31:0] wd [16];
      logic [3:0]  ws [16];
      int          n = 0;
      logic        ok;
      wi[0] = int'(a0 >> 2);
      for (int k = 0; k < nb; k++) begin
         if (k > 0) wi[k] = nxt_w(wi[k-1], bt);
         wd[k] = $urandom;
         ws[k] = 4'($urandom_range(1, 15));
      end
      for (int k = 0; k <= nb; k++) begin
         if (k == 0) begin
            do begin
               if (n == 0) begin
                  adr = 32'(wi[0]) << 2; dat = wd[0]; sel = ws[0]; we = w; bte = bt;
                  cti = (nb == 1 && !abort) ? EOB : INCR; cyc = 1'b1; stb = 1'b1;
               end
               tick(); n++;
            end while (!(ack || err) && n < 40);
         end
         if (k == nb) break;
         ok = wi[k] < MW;
         chk("burst_beat", 32'({err, ack}), ok ? 32'd1 : 32'd2);
         brd[k] = rdat;
         if (!w) chk("burst_rdata", rdat, ok ? mdl[dsel][wi[k]] : 32'h0);
         tick();
         chk("burst_adr_mismatch", 32'(mism), 32'(k == bad));
         if (w && ok) mdl[dsel][wi[k]] = bmerge(mdl[dsel][wi[k]], wd[k], ws[k]);
         if (k < nb - 1) begin
            adr = 32'(wi[k+1]) << 2;
            if (k + 1 == bad) adr = adr ^ 32'h8;
            dat = wd[k+1]; sel = ws[k+1];
            cti = (k + 1 == nb - 1 && !abort) ? EOB : INCR;
         end
      end
      if (!abort) chk("burst_end_quiet", 32'(ack | err), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      if (abort) begin
         tick();
         chk("burst_abort_quiet", 32'(ack | err), 32'd0);
      end
   endtask

   initial begin
      tick(); tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rty", 32'(rty), 32'd0);
      chk("rst_dat", rdat, 32'd0);
      chk("rst_mism", 32'(mism), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int d = 0; d < 2; d++) begin
         dsel = d;
         for (int i = 0; i < MW; i++) classic(1'b1, 32'(i * 4), $urandom, 4'hF);
      end

      // Directed cases on the zero-wait instance
      dsel = 0;
      classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      classic(1'b0, 32'h10, 32'h0, 4'hF);
      chk("rd_deadbeef", last_rd, 32'hDEADBEEF);
      classic(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF);
      classic(1'b1, 32'h20, 32'h11223344, 4'b0101);
      classic(1'b0, 32'h20, 32'h0, 4'hF);
      chk("rd_sel_merge", last_rd, 32'hAA22AA44);
      for (int i = 12; i < 16; i++) classic(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 4'hF);
      burst(1'b0, 32'h38, WRAP4, 4, -1, 1'b0);
      chk("wrap4_b0", brd[0], 32'hC0DE000E);
      chk("wrap4_b1", brd[1], 32'hC0DE000F);
      chk("wrap4_b2", brd[2], 32'hC0DE000C);
      chk("wrap4_b3", brd[3], 32'hC0DE000D);
      classic(1'b0, 32'(4 * MW), 32'h0, 4'hF);
      classic(1'b1, 32'(4 * MW), 32'h12345678, 4'hF);
      classic(1'b0, 32'h0, 32'h0, 4'hF);

      // Random traffic on the zero-wait instance
      for (int i = 0; i < 60; i++)
         classic(1'($urandom), 32'($urandom_range(0, 4 * MW + 63)), $urandom, 4'($urandom));
      for (int i = 0; i < 20; i++) begin
         int          nb, bad;
         logic [1:0]  bt;
         logic [31:0] a;
         nb  = $urandom_range(1, 8);
         bt  = 2'($urandom);
         bad = (nb > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nb - 1) : -1;
         if (bt != 2'd0 && $urandom_range(0, 4) == 0) a = 32'(MW + $urandom_range(0, 15)) << 2;
         else                                         a = 32'($urandom_range(0, MW - 1)) << 2;
         burst(1'($urandom), a, bt, nb, bad, 1'b0);
      end

      // Three-wait instance: latency, aborted burst, reset inside WAIT
      dsel = 1;
      classic(1'b1, 32'h10, 32'h5A5A1234, 4'hF);
      classic(1'b0, 32'h10, 32'h0, 4'hF);
      chk("ws3_rd", last_rd, 32'h5A5A1234);
      burst(1'b1, 32'h40, LINEAR, 2, -1, 1'b1);
      adr = 32'h10; we = 1'b0; cti = CLASSIC; cyc = 1'b1; stb = 1'b1;
      tick(); tick();
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
      tick();
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_rty", 32'(rty), 32'd0);
      chk("midrst_dat", rdat, 32'd0);
      chk("midrst_mism", 32'(mism), 32'd0);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin tick(); if (ack || err) seen++; end
         chk("postrst_no_ack", 32'(seen), 32'd0);
      end
      classic(1'b0, 32'h40, 32'h0, 4'hF);
      classic(1'b0, 32'h44, 32'h0, 4'hF);
      classic(1'b0, 32'h48, 32'h0, 4'hF);
      classic(1'b0, 32'h10, 32'h0, 4'hF);
      chk("postrst_keep", last_rd, 32'h5A5A1234);
      for (int i = 0; i < 6; i++)
         burst(1'($urandom), 32'($urandom_range(0, MW - 1)) << 2, 2'($urandom), $urandom_range(1, 6), -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_burst_slave.md
Name: wb_burst_slave

Overview:
- Synthesizable Wishbone B3 slave with on-chip word memory; the responder end of the Wishbone BFM transactor.
- Serves classic cycles and registered-feedback incrementing bursts (linear and wrap 4/8/16), with configurable wait states and address-range error response.
- Sits behind the interconnect as a reusable target for BFM regression and for SoC bring-up.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed 32 with 4 select bits.
- MEM_WORDS, 1024, memory depth in words; power of two.
- BASE_ADDR, 32'h0, byte address of word 0.
- WAIT_STATES, 0, idle cycles inserted before the first ack of every cycle (0..15).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type.
- wb_bte_i  in  2  burst type.
- wb_dat_o  out  DW  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error.
- wb_rty_o  out  1  retry; constant 0.
- adr_mismatch_o  out  1  one-cycle pulse when master address differs from internal burst address.

Behaviour:
- Reset: wb_rst_ni low at a clock edge forces FSM to IDLE and wait counter to 0. wb_ack_o, wb_err_o, wb_rty_o, adr_mismatch_o and wb_dat_o are 0. Memory contents are not cleared.
- Reset mid-burst: the cycle is abandoned and no further ack is issued.
- Outputs are registered.
- Address in range when BASE_ADDR <= adr < BASE_ADDR + 4*MEM_WORDS. Word index = (adr - BASE_ADDR) >> 2; adr[1:0] ignored.
- FSM states:
  - IDLE: cyc&stb seen. If WAIT_STATES = 0, go to RESP; otherwise go to WAIT, loading the counter with WAIT_STATES-1.
  - WAIT: decrement each cycle; at 0 go to RESP.
  - RESP: drive one ack (or err) beat.
    - cti = 000 or 111: go to IDLE.
    - cti = 001 or 010: go to BURST with next address computed.
    - cti = 011..110 (reserved): treated as 000.
  - BURST: with stb high, one ack per cycle. Beat address comes from the internal counter. When wb_adr_i differs from it, pulse adr_mismatch_o for that beat; the beat still completes at the internal address. stb low stalls with no ack. Beat with cti = 111 is acked, then go to IDLE.
- Latency with WAIT_STATES = 0: stb sampled at edge N gives ack high after edge N+1. A burst acks on consecutive cycles. Classic cycles never ack on two consecutive cycles.
- Burst address generation (word index):
  - bte 00 linear: +1, wraps mod MEM_WORDS.
  - bte 01/10/11: wrap within aligned 4/8/16-word blocks; low 2/3/4 bits increment, upper bits held.
- Writes: each byte with sel = 1 is written on the ack beat.
- Reads: wb_dat_o is valid with ack and holds its value otherwise.
- Out of range address: wb_err_o is asserted instead of ack for that beat, with no write and read data 0. A burst continues beat-by-beat; each beat is checked independently.
- cyc drop at any time: FSM goes to IDLE on the next edge, with no ack/err that cycle.
- ack and err are never both high.

Decomposition:
- Package wb_burst_pkg holds:
  - CTI constants: CLASSIC = 000, CONST = 001, INCR = 010, EOB = 111.
  - BTE constants: LINEAR, WRAP4, WRAP8, WRAP16.
  - FSM state enum.
- Sub-module wb_burst_addr_gen: combinational next-index from current index, bte and MEM_WORDS.

Test Plan:
- Classic write 32'hDEADBEEF to 0x10 with sel 1111, then read 0x10 (WAIT_STATES=0) -> ack one cycle after stb each time; read returns 32'hDEADBEEF.
- sel = 0101 write 32'h11223344 over 32'hAAAAAAAA at 0x20 -> read returns 32'hAA22AA44.
- INCR wrap4 read burst starting 0x38 (word 14), 4 beats, last cti = 111 -> words 14, 15, 12, 13 on four consecutive acks, then IDLE.
- WAIT_STATES = 3 classic read -> ack asserted exactly 4 cycles after stb is first sampled.
- Read at BASE_ADDR + 4*MEM_WORDS -> wb_err_o for one cycle, wb_ack_o stays 0, memory unchanged.
- Linear burst, cyc dropped after 2 beats, then reset pulsed mid-WAIT -> no further ack; all outputs 0 after reset; earlier written data still readable.
